// File: rtl/periph_timer_bank_pkg.sv
// Shared constants for the timer/LED/switch/7-seg peripheral bank.
//  PERIPH_BASE  : bus base address of the bank
//  OFF_*        : register offsets from PERIPH_BASE
//  TCON_*       : bit positions inside a TCON register
//  SEG_BLANK    : active-low segment pattern with every segment off
package periph_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  // Per-channel registers live at 0x10*i + {0x0,0x4,0x8}; selected by addr[3:2].
  typedef enum logic [1:0] {
    R_TH   = 2'd0,
    R_TL   = 2'd1,
    R_TCON = 2'd2,
    R_NONE = 2'd3
  } treg_e;

  localparam logic [8:0] OFF_LED    = 9'h100;
  localparam logic [8:0] OFF_SWITCH = 9'h104;
  localparam logic [8:0] OFF_DIGITS = 9'h108;

  localparam int TCON_EN   = 0;
  localparam int TCON_IE   = 1;
  localparam int TCON_PEND = 2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/periph_timer_bank_if.sv
// CPU data-bus slice seen by the peripheral bank.
//  rd/wr    : read / write strobes
//  addr     : byte address (word aligned)
//  wdata    : write data
//  rdata    : combinational read data (valid in the rd cycle)
//  rd_hit   : rd targets a mapped register
interface periph_timer_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_hit;

  modport master (output rd, wr, addr, wdata, input rdata, rd_hit);
  modport slave  (input rd, wr, addr, wdata, output rdata, rd_hit);
endinterface

// File: rtl/periph_timer_bank_seg7.sv
// Hex nibble to 7-segment decoder, purely combinational.
//  hex : 4-bit value 0..F
//  seg : active-low segments {a,b,c,d,e,f,g} (seg[6] = a)
module seg7_hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/periph_timer_bank.sv
// Memory-mapped peripheral bank: NTIMER auto-reload timers with IRQ,
// LED and switch registers, and a multiplexed hex 7-segment display.
//  clk, reset : clock, asynchronous active-high reset
//  bus        : CPU bus slave (rd, wr, addr, wdata -> rdata, rd_hit)
//  led        : LED register output
//  switch     : raw asynchronous switch inputs
//  digi       : {anode[NDIGIT-1:0], seg[6:0]}, all active-low, registered
//  irqout     : level interrupt, OR of (pend & ie) over all timers
module periph_timer_bank
  import periph_pkg::*;
#(
  parameter int NTIMER   = 2,
  parameter int LED_W    = 8,
  parameter int SW_W     = 8,
  parameter int NDIGIT   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  periph_timer_bank_if.slave    bus,
  output logic [LED_W-1:0]      led,
  input  logic [SW_W-1:0]       switch,
  output logic [NDIGIT+6:0]     digi,
  output logic                  irqout
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
  localparam logic [4:0] NT5 = 5'(NTIMER);

  // Address decode shared by the read mux and the write enables.
  logic [31:0] off;
  logic        in_win, tmr_sel;
  logic [3:0]  ch;
  treg_e       tsel;

  assign off     = bus.addr - PERIPH_BASE;
  assign in_win  = (off[31:9] == '0) && (off[1:0] == 2'b00);
  assign ch      = off[7:4];
  assign tsel    = treg_e'(off[3:2]);
  assign tmr_sel = in_win && !off[8] && ({1'b0, ch} < NT5) && (tsel != R_NONE);

  // Timer channels
  logic [NTIMER-1:0][31:0] th_a, tl_a;
  logic [NTIMER-1:0]       en_a, ie_a, pend_a;

  for (genvar g = 0; g < NTIMER; g++) begin : g_tmr
    logic [31:0] th, tl;
    logic        en, ie, pend, hit, ovf;

    assign hit = bus.wr && tmr_sel && (ch == 4'(g));
    assign ovf = en && (tl == 32'hFFFF_FFFF);

    // Bus write has priority over count/reload; reload reads the TH value
    // held before this edge, so a simultaneous TH write affects the next reload.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        th   <= '0;
        tl   <= '0;
        en   <= 1'b0;
        ie   <= 1'b0;
        pend <= 1'b0;
      end else begin
        if (hit && tsel == R_TH) th <= bus.wdata;
        if (hit && tsel == R_TL) tl <= bus.wdata;
        else if (ovf)            tl <= th;
        else if (en)             tl <= tl + 32'd1;
        if (hit && tsel == R_TCON) begin
          en <= bus.wdata[TCON_EN];
          ie <= bus.wdata[TCON_IE];
        end
        // Overflow set beats a same-cycle write-1-to-clear.
        if (ovf && ie)
          pend <= 1'b1;
        else if (hit && tsel == R_TCON && bus.wdata[TCON_PEND])
          pend <= 1'b0;
      end
    end

    assign th_a[g]   = th;
    assign tl_a[g]   = tl;
    assign en_a[g]   = en;
    assign ie_a[g]   = ie;
    assign pend_a[g] = pend;
  end

  assign irqout = |(pend_a & ie_a);

  // LED, switch synchroniser, digit register, scan state
  logic [4*NDIGIT-1:0] digits;
  logic [SW_W-1:0]     sw_s1, sw_s2;
  logic [CW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic [3:0]          nib;
  logic [6:0]          seg;
  logic                scan_last;

  assign scan_last = (scan_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led      <= '0;
      digits   <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      scan_cnt <= '0;
      idx      <= '0;
      digi     <= {{NDIGIT{1'b1}}, SEG_BLANK};
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      if (bus.wr && in_win && off[8:0] == OFF_LED)    led    <= bus.wdata[LED_W-1:0];
      if (bus.wr && in_win && off[8:0] == OFF_DIGITS) digits <= bus.wdata[4*NDIGIT-1:0];
      scan_cnt <= scan_last ? '0 : scan_cnt + CW'(1);
      if (scan_last) idx <= (idx == IW'(NDIGIT - 1)) ? '0 : idx + IW'(1);
      // digi is loaded once at the start of each slot, so a DIGITS write
      // shows up from the following slot rather than mid-slot.
      if (scan_cnt == '0) digi <= {~(NDIGIT'(1) << idx), seg};
    end
  end

  always_comb begin
    nib = 4'h0;
    for (int d = 0; d < NDIGIT; d++)
      if (idx == IW'(d)) nib = digits[d*4 +: 4];
  end

  seg7_hex_decoder u_dec (.hex(nib), .seg(seg));

  // Read mux
  always_comb begin
    bus.rdata  = '0;
    bus.rd_hit = 1'b0;
    if (bus.rd && in_win) begin
      if (tmr_sel) begin
        bus.rd_hit = 1'b1;
        for (int i = 0; i < NTIMER; i++) begin
          if (ch == 4'(i)) begin
            case (tsel)
              R_TH:    bus.rdata = th_a[i];
              R_TL:    bus.rdata = tl_a[i];
              R_TCON:  bus.rdata = {29'd0, pend_a[i], ie_a[i], en_a[i]};
              default: bus.rdata = '0;
            endcase
          end
        end
      end else begin
        case (off[8:0])
          OFF_LED:    begin bus.rd_hit = 1'b1; bus.rdata[LED_W-1:0]    = led;    end
          OFF_SWITCH: begin bus.rd_hit = 1'b1; bus.rdata[SW_W-1:0]     = sw_s2;  end
          OFF_DIGITS: begin bus.rd_hit = 1'b1; bus.rdata[4*NDIGIT-1:0] = digits; end
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_periph_timer_bank.sv
module tb_periph_timer_bank;
  import periph_pkg::*;

  localparam logic [31:0] A_TH0   = 32'h4000_0000;
  localparam logic [31:0] A_TL0   = 32'h4000_0004;
  localparam logic [31:0] A_TCON0 = 32'h4000_0008;
  localparam logic [31:0] A_TH1   = 32'h4000_0010;
  localparam logic [31:0] A_TL1   = 32'h4000_0014;
  localparam logic [31:0] A_TCON1 = 32'h4000_0018;
  localparam logic [31:0] A_LED   = 32'h4000_0100;
  localparam logic [31:0] A_SW    = 32'h4000_0104;
  localparam logic [31:0] A_DIG   = 32'h4000_0108;
  localparam logic [31:0] A_UNMAP = 32'h4000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  led, sw;
  logic [10:0] digi;
  logic        irqout;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  periph_timer_bank_if bus();

  periph_timer_bank #(
    .NTIMER(2), .LED_W(8), .SW_W(8), .NDIGIT(4), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .led(led),
    .switch(sw), .digi(digi), .irqout(irqout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h with no expected value", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic chk(input string t, input logic [31:0] e, input logic [31:0] obs);
    expect_v(t, e);
    check(obs);
  endtask

  // Caller sits on a negedge; write is taken at the next posedge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.rd = 1'b1; bus.addr = a;
    #1;
    d = bus.rdata; h = bus.rd_hit;
    bus.rd = 1'b0;
  endtask

  task automatic rd_chk(input string t, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    logic h;
    expect_v(t, e);
    bus_rd(a, d, h);
    check(d);
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    int          n;
    logic [10:0] exp_d [4];
    exp_d = '{11'b1110_0000110, 11'b1101_0001000, 11'b1011_0000001, 11'b0111_0000001};

    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    sw = 8'h00; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_digi", 32'h7FF, 32'(digi));
    chk("rst_irq", 32'h0, 32'(irqout));
    chk("rst_led", 32'h0, 32'(led));
    rd_chk("rst_tcon0", A_TCON0, 32'h0);
    rd_chk("rst_digits", A_DIG, 32'h0);

    // Overflow and reload on timer0
    bus_wr(A_TH0, 32'hFFFF_FFF0);
    bus_wr(A_TL0, 32'hFFFF_FFFE);
    bus_wr(A_TCON0, 32'h3);
    @(negedge clk);
    rd_chk("t1_tl_pre", A_TL0, 32'hFFFF_FFFF);
    chk("t1_irq_pre", 32'h0, 32'(irqout));
    @(negedge clk);
    chk("t1_irq", 32'h1, 32'(irqout));
    rd_chk("t1_tl_reload", A_TL0, 32'hFFFF_FFF0);
    rd_chk("t1_tcon", A_TCON0, 32'h7);

    // Clearing ie masks irqout but keeps pend
    bus_wr(A_TCON0, 32'h1);
    rd_chk("mask_tcon", A_TCON0, 32'h5);
    chk("mask_irq", 32'h0, 32'(irqout));
    bus_wr(A_TCON0, 32'h3);
    chk("unmask_irq", 32'h1, 32'(irqout));

    // Clear colliding with overflow: set wins; then a clean clear
    bus_wr(A_TL0, 32'hFFFF_FFFF);
    bus_wr(A_TCON0, 32'h7);
    rd_chk("t2_tcon_coll", A_TCON0, 32'h7);
    chk("t2_irq_coll", 32'h1, 32'(irqout));
    rd_chk("t2_tl_coll", A_TL0, 32'hFFFF_FFF0);
    bus_wr(A_TCON0, 32'h7);
    rd_chk("t2_tcon_clr", A_TCON0, 32'h3);
    chk("t2_irq_clr", 32'h0, 32'(irqout));
    bus_wr(A_TCON0, 32'h2);   // freeze timer0 at FFFF_FFF2, ie kept

    // Timer1 overflow with ie=0, TH written on the overflow edge
    bus_wr(A_TH1, 32'h5);
    bus_wr(A_TL1, 32'hFFFF_FFFF);
    bus_wr(A_TCON1, 32'h1);
    bus_wr(A_TH1, 32'h9);
    rd_chk("t3_tl1_oldth", A_TL1, 32'h5);
    rd_chk("t3_th1", A_TH1, 32'h9);
    rd_chk("t3_tcon1", A_TCON1, 32'h1);
    chk("t3_irq", 32'h0, 32'(irqout));
    @(negedge clk);
    rd_chk("t3_tl0_frozen", A_TL0, 32'hFFFF_FFF2);
    rd_chk("t3_tcon0", A_TCON0, 32'h2);
    rd_chk("t3_th0", A_TH0, 32'hFFFF_FFF0);
    @(negedge clk);

    // LED, switch synchroniser, unmapped and idle reads
    bus_wr(A_LED, 32'h0000_01C3);
    chk("led_out", 32'hC3, 32'(led));
    expect_v("led_hit", 32'h1);
    bus_rd(A_LED, d, h);
    check(32'(h));
    chk("led_rd", 32'hC3, d);
    bus.addr = A_LED; bus.rd = 1'b0; #1;
    chk("idle_rdata", 32'h0, bus.rdata);
    chk("idle_hit", 32'h0, 32'(bus.rd_hit));
    sw = 8'h5A;
    @(posedge clk); #1;
    rd_chk("sw_1clk", A_SW, 32'h0);
    @(posedge clk); #1;
    rd_chk("sw_2clk", A_SW, 32'h5A);
    bus_rd(A_UNMAP, d, h);
    chk("unmap_rdata", 32'h0, d);
    chk("unmap_hit", 32'h0, 32'(h));
    @(negedge clk);

    // Display scan
    bus_wr(A_DIG, 32'h0000_00A3);
    rd_chk("dig_rd", A_DIG, 32'hA3);
    repeat (20) @(negedge clk);
    n = 0;
    while (digi[10:7] == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    while (digi[10:7] != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    chk("scan_sync_timeout", 32'h0, 32'(n >= 40));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("scan_slot%0d_start", k), 32'(exp_d[k]), 32'(digi));
      repeat (3) @(negedge clk);
      chk($sformatf("scan_slot%0d_end", k), 32'(exp_d[k]), 32'(digi));
      @(negedge clk);
    end

    // Async reset mid-count with pend set
    bus_wr(A_TL0, 32'hFFFF_FFFF);
    bus_wr(A_TCON0, 32'h3);
    @(negedge clk);
    chk("t4_irq_pre", 32'h1, 32'(irqout));
    #2 reset = 1'b1;
    #1;
    chk("t4_irq", 32'h0, 32'(irqout));
    chk("t4_digi", 32'h7FF, 32'(digi));
    chk("t4_led", 32'h0, 32'(led));
    rd_chk("t4_th0", A_TH0, 32'h0);
    rd_chk("t4_tl0", A_TL0, 32'h0);
    rd_chk("t4_tcon0", A_TCON0, 32'h0);
    rd_chk("t4_th1", A_TH1, 32'h0);
    rd_chk("t4_digits", A_DIG, 32'h0);
    rd_chk("t4_switch", A_SW, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("t4_tl0_idle", A_TL0, 32'h0);
    chk("t4_irq_after", 32'h0, 32'(irqout));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expected values never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
